// File: rtl/ofc_readout_pkg.sv
// Shared types and constants for the OFC readout scheduler and its skid FIFO.
package ofc_readout_pkg;

    localparam int N_INPUT = 16;
    localparam int ADDR_W  = 15;
    localparam int DATA_W  = 16;
    localparam int HPL_W   = 10;
    localparam int CH_W    = 4;

    localparam logic [DATA_W-1:0] SYNC_WORD    = 16'hEB90;
    localparam logic [7:0]        CH_ID_PREFIX = 8'hC0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_SYNC,
        ST_HDR_EVT,
        ST_CH_ID,
        ST_CH_DATA,
        ST_TRAILER,
        ST_DONE
    } state_e;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [CH_W-1:0] lowest_set(input logic [N_INPUT-1:0] mask);
        lowest_set = '0;
        for (int i = N_INPUT - 1; i >= 0; i--) begin
            if (mask[i]) lowest_set = CH_W'(i);
        end
    endfunction

endpackage

// File: rtl/ofc_skid_fifo.sv
// Two-entry FIFO that decouples the read/issue pipeline from downstream backpressure.
module ofc_skid_fifo
    import ofc_readout_pkg::*;
#(
    parameter int W = DATA_W + 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_q;
    logic         rd_q;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (push_i && !pop_i) begin
            cnt_d = cnt_q + 2'd1;
        end else if (pop_i && !push_i) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else if (clr_i) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push_i) wr_q <= ~wr_q;
            if (pop_i)  rd_q <= ~rd_q;
            cnt_q <= cnt_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign count_o = cnt_q;

endmodule

// File: rtl/ofc_readout_scheduler.sv
// Frames buffered events from 16 sample RAMs into one packetised 16-bit stream
// (sync, event number, per-channel id + samples, XOR trailer) with valid/ready backpressure.
module ofc_readout_scheduler
    import ofc_readout_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                live_rising,
    input  logic [HPL_W-1:0]    HALF_PACKAGE_LENGTH,
    input  logic [ADDR_W-1:0]   MEMORY_DEPTH,
    input  logic [N_INPUT-1:0]  input_ena,
    input  logic [15:0]         n_write,
    output logic                ram_ren,
    output logic [ADDR_W-1:0]   ram_raddr,
    output logic [CH_W-1:0]     ram_sel,
    input  logic [DATA_W-1:0]   ram_rdata,
    output logic [DATA_W-1:0]   tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                tx_sop,
    output logic                tx_eop,
    output logic [15:0]         n_read,
    output logic                busy
);

    state_e              state_q, state_d;
    logic [N_INPUT-1:0]  ena_q, ena_d;
    logic [N_INPUT-1:0]  pend_q, pend_d;
    logic [CH_W-1:0]     chan_q, chan_d;
    logic [HPL_W-1:0]    hpl_q, hpl_d;
    logic [ADDR_W-1:0]   depth_q, depth_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [HPL_W-1:0]    idx_q, idx_d;
    logic [15:0]         nread_q, nread_d;
    logic [DATA_W-1:0]   csum_q, csum_d;
    logic                trl_sent_q, trl_sent_d;

    // One-deep issue stage: models the RAM read latency for every word type.
    logic                infl_vld_q;
    logic                infl_ram_q;
    logic                infl_trl_q;
    logic                infl_sop_q;
    logic                infl_eop_q;
    logic [DATA_W-1:0]   infl_word_q;
    logic [CH_W-1:0]     infl_sel_q;

    logic                issue, iss_ram, iss_trl, iss_sop, iss_eop;
    logic [DATA_W-1:0]   iss_word;
    logic                leave_ch;

    logic [1:0]          fifo_count;
    logic                fifo_full, fifo_empty;
    logic [DATA_W+1:0]   fifo_dout;
    logic                pop, push, can_issue;
    logic [DATA_W-1:0]   push_data;

    logic [CH_W-1:0]     first_ch, next_ch;
    logic [15:0]         base_sum;
    logic [ADDR_W-1:0]   base_wrap;
    logic [ADDR_W-1:0]   addr_inc;

    assign pop  = !fifo_empty && tx_ready;
    assign push = infl_vld_q;

    // A slot is free if buffer + in-flight leaves room, or a pop frees one this cycle
    // while the buffer is not already full.
    assign can_issue = (({1'b0, fifo_count} + {2'b00, infl_vld_q}) < 3'd2) || (pop && !fifo_full);

    // Trailer value is resolved on push so it includes the RAM word pushed just before it.
    assign push_data = infl_ram_q ? ram_rdata : (infl_trl_q ? csum_q : infl_word_q);

    assign first_ch  = lowest_set(input_ena);
    assign next_ch   = lowest_set(pend_q);
    assign base_sum  = {1'b0, base_q} + {6'd0, hpl_q};
    assign base_wrap = (depth_q == '0) ? '0 : ADDR_W'(base_sum % {1'b0, depth_q});
    assign addr_inc  = (addr_q == depth_q - 15'd1) ? '0 : addr_q + 15'd1;

    always_comb begin
        state_d    = state_q;
        ena_d      = ena_q;
        pend_d     = pend_q;
        chan_d     = chan_q;
        hpl_d      = hpl_q;
        depth_d    = depth_q;
        base_d     = base_q;
        addr_d     = addr_q;
        idx_d      = idx_q;
        nread_d    = nread_q;
        csum_d     = csum_q;
        trl_sent_d = trl_sent_q;
        issue      = 1'b0;
        iss_ram    = 1'b0;
        iss_trl    = 1'b0;
        iss_sop    = 1'b0;
        iss_eop    = 1'b0;
        iss_word   = '0;
        leave_ch   = 1'b0;

        if (push && !infl_trl_q) csum_d = csum_q ^ push_data;

        unique case (state_q)
            ST_IDLE: begin
                if (n_write > nread_q) begin
                    ena_d      = input_ena;
                    chan_d     = first_ch;
                    pend_d     = input_ena & ~(16'd1 << first_ch);
                    hpl_d      = HALF_PACKAGE_LENGTH;
                    depth_d    = MEMORY_DEPTH;
                    csum_d     = '0;
                    trl_sent_d = 1'b0;
                    state_d    = ST_HDR_SYNC;
                end
            end
            ST_HDR_SYNC: begin
                if (can_issue) begin
                    issue    = 1'b1;
                    iss_word = SYNC_WORD;
                    iss_sop  = 1'b1;
                    state_d  = ST_HDR_EVT;
                end
            end
            ST_HDR_EVT: begin
                if (can_issue) begin
                    issue    = 1'b1;
                    iss_word = nread_q;
                    state_d  = (|ena_q) ? ST_CH_ID : ST_TRAILER;
                end
            end
            ST_CH_ID: begin
                if (can_issue) begin
                    issue    = 1'b1;
                    iss_word = {CH_ID_PREFIX, 4'h0, chan_q};
                    addr_d   = base_q;
                    idx_d    = '0;
                    if (hpl_q != '0) state_d = ST_CH_DATA;
                    else             leave_ch = 1'b1;
                end
            end
            ST_CH_DATA: begin
                if (can_issue) begin
                    issue   = 1'b1;
                    iss_ram = 1'b1;
                    addr_d  = addr_inc;
                    idx_d   = idx_q + 10'd1;
                    if (idx_q == hpl_q - 10'd1) leave_ch = 1'b1;
                end
            end
            ST_TRAILER: begin
                if (!trl_sent_q && can_issue) begin
                    issue      = 1'b1;
                    iss_trl    = 1'b1;
                    iss_eop    = 1'b1;
                    trl_sent_d = 1'b1;
                end
                if (pop && fifo_dout[DATA_W]) state_d = ST_DONE;
            end
            ST_DONE: begin
                nread_d = nread_q + 16'd1;
                base_d  = base_wrap;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Disabled inputs are skipped by jumping straight to the next pending channel.
        if (leave_ch) begin
            if (|pend_q) begin
                chan_d  = next_ch;
                pend_d  = pend_q & ~(16'd1 << next_ch);
                state_d = ST_CH_ID;
            end else begin
                state_d = ST_TRAILER;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ena_q      <= '0;
            pend_q     <= '0;
            chan_q     <= '0;
            hpl_q      <= '0;
            depth_q    <= '0;
            base_q     <= '0;
            addr_q     <= '0;
            idx_q      <= '0;
            nread_q    <= '0;
            csum_q     <= '0;
            trl_sent_q <= 1'b0;
            infl_vld_q <= 1'b0;
        end else if (live_rising) begin
            state_q    <= ST_IDLE;
            ena_q      <= '0;
            pend_q     <= '0;
            chan_q     <= '0;
            hpl_q      <= '0;
            depth_q    <= '0;
            base_q     <= '0;
            addr_q     <= '0;
            idx_q      <= '0;
            nread_q    <= '0;
            csum_q     <= '0;
            trl_sent_q <= 1'b0;
            infl_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ena_q      <= ena_d;
            pend_q     <= pend_d;
            chan_q     <= chan_d;
            hpl_q      <= hpl_d;
            depth_q    <= depth_d;
            base_q     <= base_d;
            addr_q     <= addr_d;
            idx_q      <= idx_d;
            nread_q    <= nread_d;
            csum_q     <= csum_d;
            trl_sent_q <= trl_sent_d;
            infl_vld_q <= issue;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            infl_word_q <= iss_word;
            infl_ram_q  <= iss_ram;
            infl_trl_q  <= iss_trl;
            infl_sop_q  <= iss_sop;
            infl_eop_q  <= iss_eop;
            infl_sel_q  <= chan_q;
        end
    end

    ofc_skid_fifo #(.W(DATA_W + 2)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (live_rising),
        .push_i  (push),
        .din_i   ({infl_sop_q, infl_eop_q, push_data}),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Hold the select of the outstanding read through its data cycle.
    assign ram_sel   = (infl_vld_q && infl_ram_q) ? infl_sel_q : chan_q;
    assign ram_ren   = issue && iss_ram;
    assign ram_raddr = addr_q;
    assign tx_valid  = !fifo_empty;
    assign tx_data   = fifo_empty ? '0 : fifo_dout[DATA_W-1:0];
    assign tx_sop    = !fifo_empty && fifo_dout[DATA_W+1];
    assign tx_eop    = !fifo_empty && fifo_dout[DATA_W];
    assign n_read    = nread_q;
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule
